delay_probe: RTL
================

# delay_probe

Clocked launch-and-capture stage wrapped around a `delay_multi` instance. On request it toggles all N lanes driven into the delay line, samples the N returned lanes, and reports in clock cycles when the first lane and the last lane arrive. Used for delay-line characterisation and calibration. Successive measurements alternate between rising and falling edges.

## Interface
- `N`, 1: lane count. Must equal the `N` of the attached `delay_multi`.
- `CW`, 8: width of the result counters.
- `TIMEOUT`, 200: maximum edge index before a measurement is abandoned. Requires `SYNC_STAGES+2 <= TIMEOUT < 2**CW`.
- `RVAL`, 1'b0: reset value of `launch` and of the sampling flops. Matches the delay line's `Rval`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: measurement request. Sampled only in IDLE.
- `busy`, out, 1: high while a measurement is running.
- `done`, out, 1: one-cycle pulse when a measurement ends.
- `timeout`, out, 1: the last measurement hit `TIMEOUT`. Valid from `done` until the next `done`.
- `launch`, out, N: lanes driven into the delay line.
- `ret`, in, N: lanes returned from the delay line. Asynchronous to `clk`.
- `t_first`, out, CW: edge index at which the first lane arrived.
- `t_last`, out, CW: edge index at which all lanes had arrived.

## Operation
- Reset values: `busy`=0, `done`=0, `timeout`=0, `t_first`=0, `t_last`=0, `launch`={N{RVAL}}, sampling flops={N{RVAL}}, FSM=IDLE.
- FSM states are IDLE and RUN.
- IDLE → RUN: on an edge with `start`=1 (launch edge E0):
  - `launch` <= ~`launch` (all lanes toggle);
  - edge counter cleared;
  - `busy` <= 1.
- RUN: edges after E0 are numbered E1, E2, …
  - At each edge Ek, the FSM evaluates the sampled return `ret_s` against `launch`: `match` = ~(`ret_s` ^ `launch`).
  - First Ek with |`match`: `t_first` <= k. Captured once per measurement.
  - First Ek with &`match`: `t_last` <= k, plus `t_first` <= k if it was not yet captured. Then `done` pulses, `timeout` <= 0, `busy` <= 0, next state IDLE.
  - Ek with k = `TIMEOUT` and not &`match`: `t_last` <= `TIMEOUT`, and `t_first` <= `TIMEOUT` if it was never captured. Then `timeout` <= 1, `done` pulses, next state IDLE.
- `launch` is not restored after a measurement, so the next measurement uses the opposite edge polarity.
- The counter never exceeds `TIMEOUT`, so there is no wrap.
- `start` while in RUN, including on the `done` edge, is ignored. It is not queued.
- `t_first`, `t_last` and `timeout` hold their values until the next measurement updates them.
- A lane that matches and later drops its match does not undo `t_first`. `t_last` requires all lanes to match in the same sample.
- `rst` during RUN aborts the measurement immediately. No `done` pulse; all outputs go to their reset values.

## Timing
- `ret` passes through `SYNC_STAGES` sampling flops before the FSM sees it.
- Zero-delay loopback (`ret`=`launch`) gives `t_first`=`t_last`=`SYNC_STAGES`+1.
- A delay line of d whole cycles reads `SYNC_STAGES`+1+d, with ±1 cycle quantisation.
- `done` asserts in the cycle after edge E`t_last`. `busy` falls on that same edge.
- The earliest next launch edge is the edge after `done`. This gives 1 idle cycle minimum between measurements.

## Configuration
- `DELAY_PROBE_SYNC_EN` defined: `SYNC_STAGES`=2, a two-flop synchroniser per lane. Use this for real, asynchronous delay lines.
- `DELAY_PROBE_SYNC_EN` undefined: `SYNC_STAGES`=1, a single sampling flop. Use this for simulation or when the path is known to be timing-clean. Every reading is 1 lower.

## Structure
- Package `delay_probe_pkg` holds:
  - `typedef enum logic {IDLE, RUN} probe_state_t`;
  - `localparam SYNC_STAGES`, selected by `DELAY_PROBE_SYNC_EN`.
- Sub-module `sync_multi #(N, STAGES, RVAL)`: an N-wide flop chain with asynchronous active-high reset to {N{RVAL}}.
- Top level contains the FSM, the edge counter and the result registers.

## Test plan
- Reset, then loopback `ret`=`launch`, then `start` → `launch` = all 1s, `done` at E`SYNC_STAGES`+1, `t_first`=`t_last`=3 (sync on) or 2 (sync off), `timeout`=0.
- Two consecutive measurements over a 5-cycle model delay → both read 8 (sync on). `launch` returns to 0 after the second.
- N=4, lane delays 2/3/4/7 cycles, sync on → `t_first`=5, `t_last`=10.
- `ret` held at 0, `TIMEOUT`=20 → `done` at E20, `timeout`=1, `t_first`=`t_last`=20.
- `start` pulsed during RUN and on the `done` edge → exactly one measurement, no second `busy`.
- `rst` asserted mid-RUN → all outputs go to reset values asynchronously, no `done`. A following `start` measures normally.

Source files
------------

// File: rtl/delay_probe_pkg.sv
// Shared types and build-time constants for the delay_probe launch/capture stage.
// DELAY_PROBE_SYNC_EN selects a two-flop return synchroniser instead of a single sampling flop.
package delay_probe_pkg;

    typedef enum logic {IDLE, RUN} probe_state_t;

`ifdef DELAY_PROBE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

endpackage

// File: rtl/sync_multi.sv
// N-wide flop chain of STAGES flops per lane, asynchronously reset to {N{RVAL}}.
module sync_multi #(
    parameter int   N      = 1,
    parameter int   STAGES = 1,
    parameter logic RVAL   = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] sync_p [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_p[i] <= {N{RVAL}};
            end
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/delay_probe.sv
// Launch-and-capture probe around a multi-lane delay line: toggles all lanes, reports first/last arrival edge.
// Build option: DELAY_PROBE_SYNC_EN (via delay_probe_pkg) adds a second synchroniser flop per lane.
module delay_probe
    import delay_probe_pkg::*;
#(
    parameter int   N       = 1,
    parameter int   CW      = 8,
    parameter int   TIMEOUT = 200,
    parameter logic RVAL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [N-1:0]  launch,
    input  logic [N-1:0]  ret,
    output logic [CW-1:0] t_first,
    output logic [CW-1:0] t_last
);

    probe_state_t  state, state_n;
    logic [N-1:0]  ret_s, match, launch_n;
    logic [CW-1:0] cnt, cnt_n, k, t_first_n, t_last_n;
    logic          got_first, got_first_n, busy_n, done_n, timeout_n;

    sync_multi #(.N(N), .STAGES(SYNC_STAGES), .RVAL(RVAL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ret),
        .q   (ret_s)
    );

    assign match = ~(ret_s ^ launch);
    // k is the index of the edge about to occur; cnt holds the index of the previous one
    assign k     = cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            launch    <= {N{RVAL}};
            cnt       <= '0;
            got_first <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            t_first   <= '0;
            t_last    <= '0;
        end else begin
            state     <= state_n;
            launch    <= launch_n;
            cnt       <= cnt_n;
            got_first <= got_first_n;
            busy      <= busy_n;
            done      <= done_n;
            timeout   <= timeout_n;
            t_first   <= t_first_n;
            t_last    <= t_last_n;
        end
    end

    always_comb begin
        state_n     = state;
        launch_n    = launch;
        cnt_n       = cnt;
        got_first_n = got_first;
        busy_n      = busy;
        done_n      = 1'b0;
        timeout_n   = timeout;
        t_first_n   = t_first;
        t_last_n    = t_last;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = RUN;
                    launch_n    = ~launch;
                    cnt_n       = '0;
                    got_first_n = 1'b0;
                    busy_n      = 1'b1;
                end
            end
            RUN: begin
                cnt_n = k;
                if (!got_first && |match) begin
                    t_first_n   = k;
                    got_first_n = 1'b1;
                end
                if (&match) begin
                    t_last_n  = k;
                    timeout_n = 1'b0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else if (k == CW'(TIMEOUT)) begin
                    // abandoned: report TIMEOUT for any edge that never arrived
                    t_last_n = CW'(TIMEOUT);
                    if (!got_first) begin
                        t_first_n = CW'(TIMEOUT);
                    end
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
